// File: rtl/spi_adc_multi_reader.sv
// Multi-channel serial ADC reader: one shared SCLK/CS_N drives NUM_CH converters.
// Each frame is captured in parallel, one result per channel, in single-shot or continuous mode.
module spi_adc_multi_reader #(
  parameter int CLK_FREQ_HZ    = 100000000,
  parameter int SCLK_FREQ_HZ   = 12500000,
  parameter int NUM_CH         = 2,
  parameter int FRAME_BITS     = 16,
  parameter int DATA_BITS      = 12,
  parameter int DATA_OFFSET    = 3,
  parameter int T_CS_CYCLES    = 1,
  parameter int T_QUIET_CYCLES = 9,
  parameter int PERIOD_W       = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          request_i,
  input  logic                          continuous_i,
  input  logic [PERIOD_W-1:0]           period_i,
  output logic                          busy_o,
  output logic [NUM_CH*DATA_BITS-1:0]   data_o,
  output logic                          data_valid_o,
  output logic                          overrun_o,
  output logic                          sclk_o,
  output logic                          cs_n_o,
  input  logic [NUM_CH-1:0]             sdata_i
);

  localparam int CLK_DIV  = CLK_FREQ_HZ / SCLK_FREQ_HZ;
  localparam int HALF     = CLK_DIV / 2;
  localparam int PH_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W    = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam int WAIT_MAX = (T_CS_CYCLES > T_QUIET_CYCLES) ? T_CS_CYCLES : T_QUIET_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  if (SCLK_FREQ_HZ > 20000000) begin : g_bad_sclk
    $error("SCLK_FREQ_HZ must not exceed 20 MHz");
  end
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("CLK_FREQ_HZ/SCLK_FREQ_HZ must be even and at least 2");
  end
  if (DATA_OFFSET + DATA_BITS > FRAME_BITS) begin : g_bad_frame
    $error("DATA_OFFSET+DATA_BITS exceeds FRAME_BITS");
  end
  if (T_CS_CYCLES < 1 || T_QUIET_CYCLES < 1) begin : g_bad_timing
    $error("T_CS_CYCLES and T_QUIET_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    QUIET    = 3'd3,
    STROBE   = 3'd4
  } state_t;

  state_t              state;
  logic [PH_W-1:0]     ph;
  logic [BIT_W-1:0]    bit_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [PERIOD_W-1:0] pcnt;
  logic                armed;
  logic [DATA_BITS-1:0] sr [NUM_CH];

  logic period_expired;
  logic trigger;
  logic in_window;

  // armed is cleared whenever continuous mode idles off, so the first frame of a
  // continuous run starts at once while later frames wait out the period.
  assign period_expired = !armed ||
                          (({1'b0, pcnt} + (PERIOD_W+1)'(1)) >= {1'b0, period_i});
  assign trigger   = request_i || (continuous_i && period_expired);
  assign busy_o    = (state != IDLE);
  // Only the result bits are kept; header and trailing bits are never stored.
  assign in_window = (32'(bit_cnt) >= DATA_OFFSET) &&
                     (32'(bit_cnt) <  DATA_OFFSET + DATA_BITS);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ph           <= '0;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      pcnt         <= '0;
      armed        <= 1'b0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      overrun_o    <= 1'b0;
      sclk_o       <= 1'b1;
      cs_n_o       <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) sr[c] <= '0;
    end else begin
      data_valid_o <= 1'b0;
      overrun_o    <= 1'b0;
      if (pcnt != {PERIOD_W{1'b1}}) pcnt <= pcnt + 1'b1;

      case (state)
        IDLE: begin
          if (!continuous_i) armed <= 1'b0;
          if (trigger) begin
            state    <= CS_SETUP;
            cs_n_o   <= 1'b0;
            wait_cnt <= '0;
            pcnt     <= '0;
            armed    <= 1'b1;
          end
        end
        CS_SETUP: begin
          if (request_i) overrun_o <= 1'b1;
          if (wait_cnt == WAIT_W'(T_CS_CYCLES - 1)) begin
            state   <= SHIFT;
            ph      <= '0;
            bit_cnt <= '0;
            sclk_o  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (request_i) overrun_o <= 1'b1;
          if (ph == PH_W'(CLK_DIV - 1)) begin
            if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
              state    <= QUIET;
              cs_n_o   <= 1'b1;
              sclk_o   <= 1'b1;
              wait_cnt <= '0;
            end else begin
              ph      <= '0;
              bit_cnt <= bit_cnt + 1'b1;
              sclk_o  <= 1'b0;
            end
          end else begin
            ph <= ph + 1'b1;
            // Sample in the same cycle the registered SCLK rises.
            if (ph == PH_W'(HALF - 1)) begin
              sclk_o <= 1'b1;
              if (in_window) begin
                for (int c = 0; c < NUM_CH; c++)
                  sr[c] <= {sr[c][DATA_BITS-2:0], sdata_i[c]};
              end
            end
          end
        end
        QUIET: begin
          if (request_i) overrun_o <= 1'b1;
          if (wait_cnt == WAIT_W'(T_QUIET_CYCLES - 1)) begin
            state        <= STROBE;
            data_valid_o <= 1'b1;
            for (int c = 0; c < NUM_CH; c++)
              data_o[c*DATA_BITS +: DATA_BITS] <= sr[c];
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        STROBE: begin
          if (trigger) begin
            state    <= CS_SETUP;
            cs_n_o   <= 1'b0;
            wait_cnt <= '0;
            pcnt     <= '0;
            armed    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_multi_reader.sv
// Directed bench for spi_adc_multi_reader with two modelled ADCs (4 leading zeros + 12 data bits,
// first bit presented at CS_N fall, next bit on each SCLK fall).
module tb_spi_adc_multi_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        request = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] period = 16'd0;
  logic        busy, data_valid, overrun, sclk, cs_n;
  logic [23:0] data;
  logic [1:0]  sdata;

  spi_adc_multi_reader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .request_i    (request),
    .continuous_i (continuous),
    .period_i     (period),
    .busy_o       (busy),
    .data_o       (data),
    .data_valid_o (data_valid),
    .overrun_o    (overrun),
    .sclk_o       (sclk),
    .cs_n_o       (cs_n),
    .sdata_i      (sdata)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model
  logic [15:0] word0 = 16'h0, word1 = 16'h0;
  int adc_idx = 0;
  logic [3:0] bit_sel;
  always @(negedge sclk or posedge cs_n) begin
    if (cs_n) adc_idx <= 0;
    else      adc_idx <= adc_idx + 1;
  end
  assign bit_sel = 4'(15 - adc_idx);
  assign sdata   = (adc_idx < 16) ? {word1[bit_sel], word0[bit_sel]} : 2'b00;

  // event monitor, sampled on the falling clock edge
  int cs_fall_q[$], cs_rise_q[$], strobe_q[$], ovr_q[$], busy_fall_q[$];
  logic [23:0] data_q[$];
  logic [23:0] exp_q[$];
  int sclk_rises = 0;
  logic cs_prev = 1'b1, sclk_prev = 1'b1, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (cs_prev && !cs_n) cs_fall_q.push_back(cyc);
    if (!cs_prev && cs_n) cs_rise_q.push_back(cyc);
    if (!sclk_prev && sclk) sclk_rises++;
    if (busy_prev && !busy) busy_fall_q.push_back(cyc);
    if (data_valid === 1'b1) begin
      strobe_q.push_back(cyc);
      data_q.push_back(data);
    end
    if (overrun === 1'b1) ovr_q.push_back(cyc);
    cs_prev   = cs_n;
    sclk_prev = sclk;
    busy_prev = busy;
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  int t0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    cs_fall_q.delete();
    cs_rise_q.delete();
    strobe_q.delete();
    ovr_q.delete();
    busy_fall_q.delete();
    data_q.delete();
    exp_q.delete();
    sclk_rises = 0;
  endtask

  function automatic int fall_rel(input int i);
    if (i < cs_fall_q.size()) return cs_fall_q[i] - t0;
    return -1;
  endfunction

  function automatic int fall_gap(input int i);
    if (i > 0 && i < cs_fall_q.size()) return cs_fall_q[i] - cs_fall_q[i-1];
    return -1;
  endfunction

  function automatic int strobe_rel(input int i);
    if (i < strobe_q.size()) return strobe_q[i] - t0;
    return -1;
  endfunction

  function automatic int busy_fall_rel(input int i);
    if (i < busy_fall_q.size()) return busy_fall_q[i] - t0;
    return -1;
  endfunction

  task automatic check_frames(input string tag);
    logic [23:0] e;
    chk({tag, "_frame_count"}, data_q.size(), exp_q.size());
    while (exp_q.size() > 0 && data_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, {8'h0, data_q.pop_front()}, {8'h0, e});
    end
  endtask

  task automatic pulse_request();
    request = 1'b1;
    tick();
    request = 1'b0;
  endtask

  initial begin
    int n;

    // reset state
    rst = 1'b1;
    repeat (4) tick();
    chk("reset_cs_n", cs_n, 1);
    chk("reset_sclk", sclk, 1);
    chk("reset_busy", busy, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_data", data, 0);
    rst = 1'b0;
    tick();

    // single request
    word0 = 16'h0BA5; word1 = 16'h0123;
    clear_events();
    exp_q.push_back(24'h123BA5);
    t0 = cyc;
    pulse_request();
    repeat (200) tick();
    chk("t1_cs_fall_count", cs_fall_q.size(), 1);
    chk("t1_cs_fall", fall_rel(0), 1);
    chk("t1_cs_rise", (cs_rise_q.size() > 0) ? cs_rise_q[0] - t0 : -1, 130);
    chk("t1_sclk_rises", sclk_rises, 16);
    chk("t1_strobe", strobe_rel(0), 139);
    chk("t1_busy_fall", busy_fall_rel(0), 140);
    chk("t1_no_overrun", ovr_q.size(), 0);
    check_frames("t1");

    // request held high
    clear_events();
    repeat (4) exp_q.push_back(24'h123BA5);
    t0 = cyc;
    request = 1'b1;
    repeat (427) tick();
    request = 1'b0;
    repeat (300) tick();
    chk("t2_cs_fall_count", cs_fall_q.size(), 4);
    chk("t2_cs_fall0", fall_rel(0), 1);
    chk("t2_gap1", fall_gap(1), 139);
    chk("t2_gap2", fall_gap(2), 139);
    chk("t2_gap3", fall_gap(3), 139);
    chk("t2_strobe0", strobe_rel(0), 139);
    chk("t2_strobe1", strobe_rel(1), 278);
    n = 0;
    foreach (ovr_q[i]) if (ovr_q[i] - t0 >= 1 && ovr_q[i] - t0 <= 139) n++;
    chk("t2_overrun_frame1", n, 138);
    check_frames("t2");

    // continuous, period 500 then 10
    clear_events();
    repeat (6) exp_q.push_back(24'h123BA5);
    t0 = cyc;
    period = 16'd500;
    continuous = 1'b1;
    repeat (300) tick();
    chk("t3_idle_wait_busy", busy, 0);
    repeat (1300) tick();
    period = 16'd10;
    repeat (200) tick();
    continuous = 1'b0;
    repeat (300) tick();
    chk("t3_cs_fall_count", cs_fall_q.size(), 6);
    chk("t3_cs_fall0", fall_rel(0), 1);
    chk("t3_gap1", fall_gap(1), 500);
    chk("t3_gap2", fall_gap(2), 500);
    chk("t3_gap3", fall_gap(3), 500);
    chk("t3_gap4", fall_gap(4), 139);
    chk("t3_gap5", fall_gap(5), 139);
    chk("t3_no_overrun", ovr_q.size(), 0);
    check_frames("t3");

    // request pulse mid-frame
    word0 = 16'h0800; word1 = 16'h0001;
    clear_events();
    exp_q.push_back(24'h001800);
    t0 = cyc;
    pulse_request();
    repeat (49) tick();
    pulse_request();
    repeat (250) tick();
    chk("t4_overrun_count", ovr_q.size(), 1);
    chk("t4_overrun_cycle", (ovr_q.size() > 0) ? ovr_q[0] - t0 : -1, 51);
    chk("t4_cs_fall_count", cs_fall_q.size(), 1);
    chk("t4_strobe", strobe_rel(0), 139);
    check_frames("t4");

    // reset during SHIFT
    word0 = 16'h0FFF; word1 = 16'h0AAA;
    clear_events();
    t0 = cyc;
    pulse_request();
    repeat (59) tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_cs_n", cs_n, 1);
    chk("t5_rst_sclk", sclk, 1);
    chk("t5_rst_data", data, 0);
    chk("t5_rst_valid", data_valid, 0);
    chk("t5_rst_busy", busy, 0);
    rst = 1'b0;
    repeat (200) tick();
    chk("t5_no_strobe", strobe_q.size(), 0);
    word0 = 16'h0A5A; word1 = 16'h0FFF;
    clear_events();
    exp_q.push_back(24'hFFFA5A);
    t0 = cyc;
    pulse_request();
    repeat (200) tick();
    chk("t5_strobe", strobe_rel(0), 139);
    chk("t5_sclk_rises", sclk_rises, 16);
    check_frames("t5");

    // continuous dropped mid-frame
    word0 = 16'h0456; word1 = 16'h0789;
    clear_events();
    exp_q.push_back(24'h789456);
    t0 = cyc;
    period = 16'd0;
    continuous = 1'b1;
    repeat (60) tick();
    continuous = 1'b0;
    repeat (300) tick();
    chk("t6_cs_fall_count", cs_fall_q.size(), 1);
    chk("t6_strobe", strobe_rel(0), 139);
    chk("t6_busy_fall", busy_fall_rel(0), 140);
    chk("t6_busy_idle", busy, 0);
    check_frames("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
